// File: rtl/pwm_pkg.sv
// Shared constants, width helper and handshake state encoding for the RGB PWM block.
package pwm_pkg;

  localparam int unsigned PWM_INTERVAL_DEF = 1200;

  // Counter/duty width for a given period; never narrower than one bit.
  function automatic int unsigned dw_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, saturating compare and registered drive.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter  int unsigned PWM_INTERVAL = PWM_INTERVAL_DEF,
  localparam int unsigned DW           = dw_of(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_duty,
  input  logic [DW-1:0] cnt_next,
  output logic          pwm
);

  localparam logic [DW:0] LIMIT = PWM_INTERVAL[DW:0];

  logic [DW-1:0] duty;
  logic [DW-1:0] duty_next;
  logic          sat;

  always_comb begin
    duty_next = load ? load_duty : duty;
    sat       = ({1'b0, duty_next} >= LIMIT);
  end

  // Lookahead: drive for the coming cycle uses its counter value and duty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      duty <= duty_next;
      pwm  <= sat || (cnt_next < duty_next);
    end
  end

endmodule

// File: rtl/pwm_rgb.sv
// Three-channel PWM with a one-deep duty buffer applied atomically at period wrap.
module pwm_rgb
  import pwm_pkg::*;
#(
  parameter  int unsigned PWM_INTERVAL = PWM_INTERVAL_DEF,
  localparam int unsigned DW           = dw_of(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] duty_r,
  input  logic [DW-1:0] duty_g,
  input  logic [DW-1:0] duty_b,
  input  logic          duty_valid,
  output logic          duty_ready,
  output logic          pwm_r,
  output logic          pwm_g,
  output logic          pwm_b,
  output logic          period_start
);

  localparam logic [DW-1:0] LAST = DW'(PWM_INTERVAL - 1);

  logic          run;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_next;
  logic          wrap;
  logic          xfer;
  logic          load;
  logic          ready_next;
  logic [DW-1:0] pend_r;
  logic [DW-1:0] pend_g;
  logic [DW-1:0] pend_b;
  state_t        state;
  state_t        state_next;

  assign wrap = run && (cnt == LAST);
  assign xfer = duty_valid && duty_ready;

  // The cycle right after reset is the first cycle of a fresh period.
  always_comb begin
    cnt_next = cnt + DW'(1);
    if (!run || wrap) cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY:   if (xfer) state_next = FULL;
      FULL:    if (wrap) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    load       = 1'b0;
    ready_next = 1'b0;
    if (state == FULL && wrap) load = 1'b1;
    if (state_next == EMPTY)   ready_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run          <= 1'b0;
      cnt          <= '0;
      duty_ready   <= 1'b0;
      period_start <= 1'b0;
      pend_r       <= '0;
      pend_g       <= '0;
      pend_b       <= '0;
    end else begin
      run          <= 1'b1;
      cnt          <= cnt_next;
      duty_ready   <= ready_next;
      period_start <= (cnt_next == '0);
      if (xfer) begin
        pend_r <= duty_r;
        pend_g <= duty_g;
        pend_b <= duty_b;
      end
    end
  end

  pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch_r (
    .clk(clk), .rst_n(rst_n), .load(load), .load_duty(pend_r), .cnt_next(cnt_next), .pwm(pwm_r)
  );
  pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch_g (
    .clk(clk), .rst_n(rst_n), .load(load), .load_duty(pend_g), .cnt_next(cnt_next), .pwm(pwm_g)
  );
  pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch_b (
    .clk(clk), .rst_n(rst_n), .load(load), .load_duty(pend_b), .cnt_next(cnt_next), .pwm(pwm_b)
  );

endmodule
